// File: rtl/sar_ctrl.sv
// sar_ctrl: digital side of a SAR ADC. Sequences sample, bit-trial,
// comparator strobe and comparator reset phases. It drives the cap-DAC trial
// code MSB first and returns an NBITS offset-binary code with a one-cycle
// dout_valid pulse.
//
// Optional feature: define SAR_TIMEOUT_EN to add a comparator watchdog.
// The watchdog bounds each STROBE/CRST wait to TIMEOUT_CYC cycles and raises
// a sticky err flag. Without the macro the controller waits indefinitely and
// err is tied low.
module sar_ctrl #(
  parameter int NBITS       = 8,
  parameter int SAMPLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             cmp_p,
  input  logic             cmp_n,
  output logic             smpl,
  output logic             cmp_clk,
  output logic [NBITS-1:0] dac_p,
  output logic [NBITS-1:0] dac_n,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             err
);

  localparam int IDX_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SCNT_W = $clog2(SAMPLE_CYC + 1);
  localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(NBITS - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    STROBE,
    CRST,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [SCNT_W-1:0] scnt;
  logic              resolved;
  logic              released;
  logic              tout;

  // A decision is valid only when the comparator rails disagree; 1/1 counts as unresolved.
  assign resolved = cmp_p ^ cmp_n;
  assign released = ~cmp_p & ~cmp_n;
  assign dac_n    = ~dac_p;

`ifdef SAR_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0] tcnt;

  assign tout = (tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts cycles spent in the current STROBE/CRST visit; err is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if ((state_nxt != state) || !((state == STROBE) || (state == CRST)))
        tcnt <= '0;
      else
        tcnt <= tcnt + TCNT_W'(1);
      if (enable && tout &&
          (((state == STROBE) && !resolved) || ((state == CRST) && !released)))
        err <= 1'b1;
    end
  end
`else
  // Timeout disabled: tout is constant 0; TIMEOUT_CYC is referenced only so the
  // parameter list is identical in both builds.
  assign tout = (TIMEOUT_CYC < 0);
  assign err  = 1'b0;
`endif

  // Next-state logic; a low enable overrides every transition and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SAMPLE;
      SAMPLE:  if (scnt == SCNT_LAST) state_nxt = TRIAL;
      TRIAL:   state_nxt = STROBE;
      STROBE:  if (resolved || tout) state_nxt = CRST;
      CRST:    if (released || tout) state_nxt = (idx == '0) ? DONE : TRIAL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // State register, registered Moore outputs and the successive-approximation datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      smpl       <= 1'b0;
      cmp_clk    <= 1'b0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dac_p      <= '0;
      dout       <= '0;
      idx        <= IDX_TOP;
      scnt       <= '0;
    end else begin
      state      <= state_nxt;
      smpl       <= (state_nxt == SAMPLE);
      cmp_clk    <= (state_nxt == STROBE);
      busy       <= (state_nxt != IDLE);
      dout_valid <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: begin
            if (start) begin
              dac_p <= '0;
              idx   <= IDX_TOP;
              scnt  <= '0;
            end
          end
          SAMPLE: scnt <= scnt + SCNT_W'(1);
          // Trial bit is set on the way into STROBE so the comparator sees it while strobed.
          TRIAL:  dac_p[idx] <= 1'b1;
          STROBE: begin
            if ((resolved && !cmp_p) || (!resolved && tout))
              dac_p[idx] <= 1'b0;
          end
          CRST: begin
            if ((released || tout) && (idx != '0))
              idx <= idx - IDX_W'(1);
          end
          DONE: begin
            dout       <= dac_p;
            dout_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Testbench for sar_ctrl. A behavioural comparator (configurable resolve and
// release delays, or stuck at 0/0) closes the loop around the DUT. A
// binary-search reference model supplies expected codes and trial sequences.
module tb_sar_ctrl;

  localparam int NBITS       = 8;
  localparam int SAMPLE_CYC  = 2;
  localparam int TIMEOUT_CYC = 15;
  localparam int BASE_LAT    = SAMPLE_CYC + 3 * NBITS + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             start;
  logic             cmp_p;
  logic             cmp_n;
  logic             smpl;
  logic             cmp_clk;
  logic [NBITS-1:0] dac_p;
  logic [NBITS-1:0] dac_n;
  logic [NBITS-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  // comparator model state
  logic [7:0] vin = 8'h00;
  int         res_dly = 0;
  int         rel_dly = 0;
  logic       stuck = 1'b0;
  int         hi_cnt = 0;
  int         lo_cnt = 100;
  logic [1:0] last_dec = 2'b00;

  // monitor state
  logic       mon_on = 1'b0;
  logic       cmp_clk_q = 1'b0;
  int         dacn_bad = 0;
  int         trial_n = 0;
  logic [7:0] trial_log [0:1023];
  int         last_base = 0;
  int         cyc = 0;

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_code;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] a5_trials [8];

  sar_ctrl #(
    .NBITS(NBITS),
    .SAMPLE_CYC(SAMPLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .start(start),
    .cmp_p(cmp_p),
    .cmp_n(cmp_n),
    .smpl(smpl),
    .cmp_clk(cmp_clk),
    .dac_p(dac_p),
    .dac_n(dac_n),
    .dout(dout),
    .dout_valid(dout_valid),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: resolves res_dly cycles after the strobe rises and holds its
  // decision for rel_dly cycles after the strobe falls.
  always @(posedge clk) begin
    if (cmp_clk === 1'b1) begin
      hi_cnt <= hi_cnt + 1;
      lo_cnt <= 0;
      if (cmp_p ^ cmp_n) last_dec <= {cmp_p, cmp_n};
    end else begin
      hi_cnt <= 0;
      if (lo_cnt < 1000) lo_cnt <= lo_cnt + 1;
    end
  end

  always_comb begin
    cmp_p = 1'b0;
    cmp_n = 1'b0;
    if (!stuck) begin
      if (cmp_clk === 1'b1) begin
        if (hi_cnt >= res_dly) begin
          cmp_p = (vin >= dac_p);
          cmp_n = ~cmp_p;
        end
      end else if (lo_cnt < rel_dly) begin
        cmp_p = last_dec[1];
        cmp_n = last_dec[0];
      end
    end
  end

  // Monitor: dac_n complement every cycle, and the DAC code at each strobe rise.
  always @(negedge clk) begin
    if (mon_on) begin
      if (dac_n !== ~dac_p) dacn_bad++;
      if ((cmp_clk === 1'b1) && !cmp_clk_q) begin
        if (trial_n < 1024) trial_log[trial_n] = dac_p;
        trial_n++;
      end
      cmp_clk_q = (cmp_clk === 1'b1);
    end
  end

  // Reference model: ideal MSB-first binary search.
  function automatic logic [7:0] ref_code(input logic [7:0] v);
    int code = 0;
    int t;
    for (int b = NBITS - 1; b >= 0; b--) begin
      t = code | (1 << b);
      if (int'(v) >= t) code = t;
    end
    return 8'(code);
  endfunction

  function automatic logic [7:0] ref_trial(input logic [7:0] v, input int k);
    int code = 0;
    int t;
    for (int b = NBITS - 1; b >= 0; b--) begin
      t = code | (1 << b);
      if ((NBITS - 1 - b) == k) return 8'(t);
      if (int'(v) >= t) code = t;
    end
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Runs one conversion from IDLE; entered and left at posedge+#1.
  task automatic run_conv(input logic [7:0] v, input int rd, input int ld,
                          input logic [7:0] exp_code, input int exp_lat,
                          input logic [7:0] trial_vin);
    int   lat;
    logic done;
    vin       = v;
    res_dly   = rd;
    rel_dly   = ld;
    last_base = trial_n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    done  = 1'b0;
    while (!done && (lat < 600)) begin
      @(posedge clk);
      #1;
      lat++;
      if (dout_valid) done = 1'b1;
    end
    chk("conv_done", 32'(done), 32'd1);
    chk("dout", 32'(dout), 32'(exp_code));
    chk("latency", lat, exp_lat);
    chk("busy_at_valid", 32'(busy), 32'd0);
    chk("trial_count", trial_n - last_base, NBITS);
    for (int k = 0; k < NBITS; k++)
      chk("trial_code", 32'(trial_log[(last_base + k) % 1024]), 32'(ref_trial(trial_vin, k)));
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] dout_before;
    int         rd;
    int         ld;
    int         npulse;
    int         pc [3];
    logic [7:0] pd [3];
    int         low [3];
    int         rises;
    logic       prev;
    int         seen_valid;
    int         seen_busy;

    vecs[0] = '{8'hA5, 8'hA5, BASE_LAT};
    vecs[1] = '{8'h00, 8'h00, BASE_LAT};
    vecs[2] = '{8'hFF, 8'hFF, BASE_LAT};
    vecs[3] = '{8'h01, 8'h01, BASE_LAT};
    vecs[4] = '{8'h80, 8'h80, BASE_LAT};
    vecs[5] = '{8'h7F, 8'h7F, BASE_LAT};
    a5_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    rst    = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_smpl", 32'(smpl), 0);
    chk("rst_cmp_clk", 32'(cmp_clk), 0);
    chk("rst_dac_p", 32'(dac_p), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // table-driven directed conversions, ideal one-cycle comparator
    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].vin, 0, 0, vecs[i].exp_code, vecs[i].exp_lat, vecs[i].vin);
      if (i == 0)
        for (int k = 0; k < 8; k++)
          chk("a5_trial_seq", 32'(trial_log[(last_base + k) % 1024]), 32'(a5_trials[k]));
      repeat (2) @(posedge clk);
      #1;
    end

    // random inputs and random comparator resolve/release delays
    for (int i = 0; i < 12; i++) begin
      v  = 8'($urandom_range(0, 255));
      rd = $urandom_range(0, 2);
      ld = $urandom_range(0, 2);
      run_conv(v, rd, ld, ref_code(v), SAMPLE_CYC + NBITS * (3 + rd + ld) + 1, v);
      chk("err_idle", 32'(err), 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    // start held high: back-to-back conversions, one IDLE cycle between them
    vin     = 8'h3C;
    res_dly = 0;
    rel_dly = 0;
    start   = 1'b1;
    npulse  = 0;
    low     = '{0, 0, 0};
    pc      = '{0, 0, 0};
    pd      = '{8'h00, 8'h00, 8'h00};
    for (int c = 0; (c < 300) && (npulse < 3); c++) begin
      @(posedge clk);
      #1;
      if ((npulse >= 1) && !busy) low[npulse]++;
      if (dout_valid) begin
        pc[npulse] = cyc;
        pd[npulse] = dout;
        npulse++;
        if (npulse == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", npulse, 3);
    chk("b2b_gap1", pc[1] - pc[0], BASE_LAT + 1);
    chk("b2b_gap2", pc[2] - pc[1], BASE_LAT + 1);
    chk("b2b_busy_low1", low[1], 1);
    chk("b2b_busy_low2", low[2], 1);
    for (int k = 0; k < 3; k++) chk("b2b_dout", 32'(pd[k]), 32'h3C);
    @(posedge clk);
    #1;
    chk("b2b_idle_after", 32'(busy), 0);

    // enable dropped during the strobe of bit NBITS-4
    dout_before = dout;
    vin   = 8'h5A;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rises = 0;
    prev  = cmp_clk;
    for (int c = 0; (c < 100) && (rises < 4); c++) begin
      @(posedge clk);
      #1;
      if (cmp_clk && !prev) rises++;
      prev = cmp_clk;
    end
    chk("en_reached_strobe", rises, 4);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_busy", 32'(busy), 0);
    chk("en_cmp_clk", 32'(cmp_clk), 0);
    chk("en_smpl", 32'(smpl), 0);
    chk("en_dout_valid", 32'(dout_valid), 0);
    chk("en_dout_kept", 32'(dout), 32'(dout_before));
    chk("en_dac_kept", 32'(dac_p), 32'(ref_trial(8'h5A, 3)));
    seen_valid = 0;
    seen_busy  = 0;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid) seen_valid++;
      if (busy) seen_busy++;
    end
    start = 1'b0;
    chk("en_low_no_valid", seen_valid, 0);
    chk("en_low_no_start", seen_busy, 0);
    enable = 1'b1;
    @(posedge clk);
    #1;

    // rst during SAMPLE, then a normal conversion
    vin   = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rs_in_sample", 32'(smpl), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rs_smpl", 32'(smpl), 0);
    chk("rs_cmp_clk", 32'(cmp_clk), 0);
    chk("rs_dac_p", 32'(dac_p), 0);
    chk("rs_dout", 32'(dout), 0);
    chk("rs_dout_valid", 32'(dout_valid), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_err", 32'(err), 0);
    run_conv(8'h96, 0, 0, 8'h96, BASE_LAT, 8'h96);

`ifdef SAR_TIMEOUT_EN
    // comparator stuck at 0/0: every bit times out and is forced to 0
    stuck = 1'b1;
    run_conv(8'h77, 0, 0, 8'h00, SAMPLE_CYC + NBITS * (TIMEOUT_CYC + 2) + 1, 8'h00);
    chk("to_err_set", 32'(err), 1);
    stuck = 1'b0;
    run_conv(8'h42, 0, 0, 8'h42, BASE_LAT, 8'h42);
    chk("to_err_sticky", 32'(err), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("to_err_cleared", 32'(err), 0);
`else
    // comparator stuck at 0/0: controller keeps strobing indefinitely
    stuck = 1'b1;
    vin   = 8'h77;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("stuck_busy", 32'(busy), 1);
    chk("stuck_cmp_clk", 32'(cmp_clk), 1);
    chk("stuck_no_valid", 32'(dout_valid), 0);
    chk("stuck_err", 32'(err), 0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("stuck_abort", 32'(busy), 0);
    enable = 1'b1;
    stuck  = 1'b0;
`endif

    @(posedge clk);
    #1;
    chk("dac_n_complement", dacn_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
